// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and defaults for the registered valid/ready pipeline stage.
// Holds the occupancy state encoding and the default datapath width.
package pipe_stage_reg_pkg;

    localparam int PSR_DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } psr_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline stage.
// The master drives valid and data, and the slave drives ready.
interface pipe_stage_reg_if
    import pipe_stage_reg_pkg::*;
#(
    parameter int WIDTH = PSR_DEF_WIDTH
) ();
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_data_reg.sv
// One WIDTH-bit data slice with a load enable and an asynchronous reset to RESET_VALUE.
// It is used for both the main register and the skid register of the stage.
module pipe_data_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH       = PSR_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RESET_VALUE;
        else if (ld) q <= d;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Fully registered two-entry pipeline stage built from a main register and a skid register.
// in_ready and out_valid come straight from flops, so no combinational path runs from ready to ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               WIDTH       = PSR_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    pipe_stage_reg_if.slave          up,
    pipe_stage_reg_if.master         dn
);
    psr_state_e       state;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_ld;
    logic             skid_ld;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = up.valid & in_ready_q;
    assign out_fire = out_valid_q & dn.ready;

    assign up.ready = in_ready_q;
    assign dn.valid = out_valid_q;
    assign dn.data  = main_q;

    // A flush blocks every data load; the registers keep stale contents behind out_valid=0.
    always_comb begin
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = up.data;
        if (!flush) begin
            unique case (state)
                EMPTY: main_ld = in_fire;
                ONE: begin
                    main_ld = in_fire & out_fire;
                    skid_ld = in_fire & ~out_fire;
                end
                TWO: begin
                    main_ld = out_fire;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: if (in_fire) begin
                    state       <= ONE;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state       <= TWO;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                TWO: if (out_fire) begin
                    state       <= ONE;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (main_ld),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (skid_ld),
        .d     (up.data),
        .q     (skid_q)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three stages are driven in lockstep: a 32-bit stage with reset value 0, and 1-bit and 64-bit stages with all-ones reset values.
// They are compared each cycle against a bounded two-entry FIFO model of accepted beats.
module tb_pipe_stage_reg;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] q [$];

    pipe_stage_reg_if #(.WIDTH(32)) up0 ();
    pipe_stage_reg_if #(.WIDTH(32)) dn0 ();
    pipe_stage_reg_if #(.WIDTH(1))  up1 ();
    pipe_stage_reg_if #(.WIDTH(1))  dn1 ();
    pipe_stage_reg_if #(.WIDTH(64)) up2 ();
    pipe_stage_reg_if #(.WIDTH(64)) dn2 ();

    assign up0.valid = in_valid;  assign up0.data = in_data[31:0]; assign dn0.ready = out_ready;
    assign up1.valid = in_valid;  assign up1.data = in_data[0];    assign dn1.ready = out_ready;
    assign up2.valid = in_valid;  assign up2.data = in_data;       assign dn2.ready = out_ready;

    pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(32'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up(up0), .dn(dn0));
    pipe_stage_reg #(.WIDTH(1), .RESET_VALUE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up(up1), .dn(dn1));
    pipe_stage_reg #(.WIDTH(64), .RESET_VALUE({64{1'b1}})) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up(up2), .dn(dn2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        logic exp_ir, exp_ov;
        exp_ir = (q.size() < 2);
        exp_ov = (q.size() > 0);
        chk({tag, " ir32"}, 64'(up0.ready), 64'(exp_ir));
        chk({tag, " ov32"}, 64'(dn0.valid), 64'(exp_ov));
        chk({tag, " ir1"},  64'(up1.ready), 64'(exp_ir));
        chk({tag, " ov1"},  64'(dn1.valid), 64'(exp_ov));
        chk({tag, " ir64"}, 64'(up2.ready), 64'(exp_ir));
        chk({tag, " ov64"}, 64'(dn2.valid), 64'(exp_ov));
        if (exp_ov) begin
            chk({tag, " od32"}, 64'(dn0.data), {32'd0, q[0][31:0]});
            chk({tag, " od1"},  64'(dn1.data), {63'd0, q[0][0]});
            chk({tag, " od64"}, dn2.data,      q[0]);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " ov"},   64'(dn0.valid | dn1.valid | dn2.valid), 64'd0);
        chk({tag, " ir"},   64'(up0.ready & up1.ready & up2.ready), 64'd1);
        chk({tag, " od32"}, 64'(dn0.data), 64'd0);
        chk({tag, " od1"},  64'(dn1.data), 64'd1);
        chk({tag, " od64"}, dn2.data,      {64{1'b1}});
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model by one edge, then check at the next negedge.
    task automatic step(input string tag, input logic v, input logic [63:0] d,
                        input logic ordy, input logic fl);
        logic inf, outf;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        inf  = v && (q.size() < 2);
        outf = ordy && (q.size() > 0);
        if (fl) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf)  q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        check_all("post_reset");

        step("single_aa", 1'b1, 64'hAA, 1'b1, 1'b0);
        step("single_drain", 1'b0, rnd64(), 1'b1, 1'b0);
        step("single_idle", 1'b0, rnd64(), 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) step("stream", 1'b1, 64'(i), 1'b1, 1'b0);
        repeat (2) step("stream_drain", 1'b0, rnd64(), 1'b1, 1'b0);

        step("bp_11", 1'b1, 64'h11, 1'b0, 1'b0);
        step("bp_22", 1'b1, 64'h22, 1'b0, 1'b0);
        step("bp_33_held", 1'b1, 64'h33, 1'b0, 1'b0);
        step("bp_33_held", 1'b1, 64'h33, 1'b0, 1'b0);
        step("bp_release", 1'b1, 64'h33, 1'b1, 1'b0);
        step("bp_33_acc", 1'b1, 64'h33, 1'b1, 1'b0);
        repeat (3) step("bp_drain", 1'b0, rnd64(), 1'b1, 1'b0);

        step("fl_fill", 1'b1, 64'hA1, 1'b0, 1'b0);
        step("fl_fill", 1'b1, 64'hB2, 1'b0, 1'b0);
        step("fl_two", 1'b1, 64'hC3, 1'b1, 1'b1);
        step("fl_one_ld", 1'b1, 64'hD4, 1'b0, 1'b0);
        step("fl_one", 1'b1, 64'hE5, 1'b0, 1'b1);
        repeat (3) step("fl_after", 1'b0, rnd64(), 1'b1, 1'b0);

        step("ar_load", 1'b1, 64'h5A, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_first", 1'b1, 64'h77, 1'b1, 1'b0);
        step("ar_drain", 1'b0, rnd64(), 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic v, r, f;
            v = ($urandom_range(99) < 70);
            r = ($urandom_range(99) < 60);
            f = ($urandom_range(99) < 4);
            step("rand", v, rnd64(), r, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, is the data path width in bits and SHALL be at least 1.
REQ-002 Parameter RESET_VALUE, default 0, is the value of both data registers after reset.
REQ-003 CLK  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  input  1  is the reset, asynchronous and active-low.
REQ-005 FLUSH  input  1  is a synchronous pipeline flush (hazard/branch kill).
REQ-006 IN_VALID  input  1  means the upstream stage offers IN_DATA.
REQ-007 IN_DATA  input  WIDTH  is the upstream payload.
REQ-008 IN_READY  output  1  means this stage accepts a beat this cycle.
REQ-009 OUT_VALID  output  1  means OUT_DATA holds a valid beat.
REQ-010 OUT_DATA  output  WIDTH  is the downstream payload.
REQ-011 OUT_READY  input  1  means downstream accepts the beat this cycle.

Function
REQ-012 An input transfer (in_fire) SHALL occur when IN_VALID and IN_READY are both 1; an output transfer (out_fire) SHALL occur when OUT_VALID and OUT_READY are both 1.
REQ-013 Storage SHALL be a main register (drives OUT_DATA) plus a skid register, with a state machine of EMPTY, ONE and TWO.
REQ-014 OUT_VALID SHALL be 1 exactly when the state is not EMPTY, and IN_READY SHALL be 1 exactly when the state is not TWO; both come directly from state flops, with no combinational path from OUT_READY to IN_READY.
REQ-015 In EMPTY: in_fire SHALL load main from IN_DATA and go to ONE; otherwise EMPTY is held.
REQ-016 In ONE: in_fire with out_fire SHALL load main from IN_DATA and stay in ONE; in_fire alone SHALL load skid and go to TWO; out_fire alone SHALL go to EMPTY; with neither, ONE is held.
REQ-017 In TWO: out_fire SHALL copy skid into main and go to ONE; otherwise TWO is held and no input is accepted.
REQ-018 Latency from in_fire to OUT_VALID=1 SHALL be exactly 1 cycle; sustained throughput SHALL be 1 beat per cycle when OUT_READY stays 1.
REQ-019 While OUT_VALID=1 and OUT_READY=0, OUT_DATA SHALL hold stable; beats SHALL never be dropped, duplicated or reordered.
REQ-020 FLUSH=1 SHALL take priority over all other events: next state is EMPTY, and any in_fire that cycle is discarded. Data registers keep their contents; OUT_VALID=0 next cycle.
REQ-021 IN_DATA SHALL be sampled only on in_fire; X on IN_DATA while IN_VALID=0 SHALL NOT propagate to the state.

Reset
REQ-022 RST_N=0 SHALL immediately force state EMPTY, so OUT_VALID=0 and IN_READY=1, and set main and skid to RESET_VALUE, independent of CLK.
REQ-023 Reset asserted mid-transfer SHALL discard all held beats; after deassertion, the first rising edge SHALL behave as in EMPTY.

Structure
REQ-024 A shared package SHALL hold the state enumeration (EMPTY, ONE, TWO) and the default datapath width constant 32.
REQ-025 Each data slice SHALL be a sub-module, pipe_data_reg (WIDTH-bit, async active-low reset to RESET_VALUE, load enable), instantiated twice: once for main, once for skid.

Verification
REQ-026 Reset then single beat: RST_N low then high, IN_VALID=1 with IN_DATA=0x0000_00AA for one cycle, OUT_READY=1 -> OUT_VALID=1 with OUT_DATA=0x0000_00AA on the next cycle only.
REQ-027 Streaming: 8 consecutive beats 1..8 with OUT_READY=1 -> outputs 1..8 on consecutive cycles with IN_READY constantly 1.
REQ-028 Backpressure: beats 0x11, 0x22, 0x33 offered with OUT_READY=0 -> 0x11 in main, 0x22 in skid, IN_READY=0 and 0x33 held upstream; then OUT_READY=1 -> outputs 0x11, 0x22, 0x33 in order, with no loss.
REQ-029 Flush in TWO with in_fire pending: FLUSH=1 for one cycle -> next cycle OUT_VALID=0 and IN_READY=1, and no flushed beat appears later.
REQ-030 Async reset mid-stream: RST_N low between clock edges while in ONE -> OUT_VALID=0 and OUT_DATA=RESET_VALUE immediately, before the next edge.
REQ-031 Parameter sweep: WIDTH=1 and WIDTH=64 with RESET_VALUE=all-ones rerun REQ-027 and REQ-028 -> identical ordering, with reset data equal to all-ones.
